// File: rtl/flit_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// flit_rr_arbiter_pkg
//   Shared types for the wormhole flit arbiter.
//   - flit_t       : one flit as pushed into the shared flit_queue
//   - arb_state_e  : arbiter lock state (idle = free to arbitrate,
//                    locked = a packet is in flight)
//   - owner_width  : index width for N sources (never below 1 bit)
//   - rr_next      : round-robin successor of an index, wrapping at n
// ----------------------------------------------------------------------------
package flit_rr_arbiter_pkg;

  localparam int FLIT_W = 32;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/flit_rr_arbiter_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
//   Combinational rotating-priority picker. Finds the first asserted request
//   searching ptr, ptr+1, ... (mod N).
//   Ports:
//     req  in  [N-1:0]      request vector
//     ptr  in  [IDX_W-1:0]  highest-priority index this cycle
//     gnt  out [N-1:0]      one-hot grant (all zero when no request)
//     idx  out [IDX_W-1:0]  index of the granted request (0 when none)
//     any  out              at least one request present
// ----------------------------------------------------------------------------
module rr_priority_picker
  import flit_rr_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = owner_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk from the farthest offset back to the pointer so that the nearest
  // requester (smallest offset) is the last one written and wins.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flit_rr_arbiter.sv
// ----------------------------------------------------------------------------
// flit_rr_arbiter
//   Wormhole round-robin arbiter sharing one flit_queue push port among
//   NUM_INPUTS flit sources. A source is granted per packet and keeps the
//   grant until its tail flit is accepted. Flits go through one output
//   register stage sitting directly in front of the queue.
//
//   Optional feature macro: FLIT_ARB_TIMEOUT_EN
//     When defined, a watchdog releases the lock after the owner has been
//     idle for TIMEOUT_CYCLES consecutive cycles and pulses timeout_pulse.
//     When undefined there is no counter and no timeout_pulse port.
//
//   Ports:
//     clk             in   clock
//     rst_n           in   asynchronous active-low reset
//     in_flit         in   per-source flit
//     in_flit_valid   in   per-source valid
//     in_flit_last    in   per-source tail marker (qualified by valid)
//     in_flit_ready   out  per-source ready, at most one bit high
//     out_flit        out  registered flit to queue
//     out_flit_valid  out  registered valid to queue
//     out_flit_ready  in   queue can take the registered flit
//     grant_owner     out  index of the current / most recent owner
//     timeout_pulse   out  watchdog fired (FLIT_ARB_TIMEOUT_EN only)
// ----------------------------------------------------------------------------
module flit_rr_arbiter
  import flit_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int OWNER_W       = owner_width(NUM_INPUTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  flit_t [NUM_INPUTS-1:0] in_flit,
  input  logic [NUM_INPUTS-1:0]  in_flit_valid,
  input  logic [NUM_INPUTS-1:0]  in_flit_last,
  output logic [NUM_INPUTS-1:0]  in_flit_ready,
  output flit_t                  out_flit,
  output logic                   out_flit_valid,
  input  logic                   out_flit_ready,
  output logic [OWNER_W-1:0]     grant_owner
`ifdef FLIT_ARB_TIMEOUT_EN
  ,
  output logic                   timeout_pulse
`endif
);

  if (NUM_INPUTS < 1) begin : g_bad_inputs
    $error("flit_rr_arbiter: NUM_INPUTS must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("flit_rr_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  arb_state_e         state_reg;
  logic [OWNER_W-1:0] rr_ptr_reg;
  logic [OWNER_W-1:0] owner_reg;
  logic               out_valid_reg;
  flit_t              out_flit_reg;

  logic [NUM_INPUTS-1:0] pick_gnt;
  logic [OWNER_W-1:0]    pick_idx;
  logic                  pick_any;

  logic               slot_free;
  logic [OWNER_W-1:0] sel_idx;
  logic               sel_valid;
  logic               sel_last;
  logic               accept;
  logic [OWNER_W-1:0] next_ptr;

  rr_priority_picker #(
    .N     (NUM_INPUTS),
    .IDX_W (OWNER_W)
  ) u_picker (
    .req (in_flit_valid),
    .ptr (rr_ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The output register can take a new flit when it is empty or being
  // drained this cycle.
  assign slot_free = !out_valid_reg || out_flit_ready;

  // While locked only the owner is considered, whatever the others request.
  assign sel_idx   = (state_reg == ARB_IDLE) ? pick_idx : owner_reg;
  assign sel_valid = (state_reg == ARB_IDLE) ? pick_any : in_flit_valid[owner_reg];
  assign sel_last  = in_flit_last[sel_idx];
  assign accept    = sel_valid && slot_free;
  assign next_ptr  = OWNER_W'(rr_next(int'(sel_idx), NUM_INPUTS));

  // Ready is gated by rst_n so no source sees a handshake while the
  // arbiter is held in reset (the state would otherwise offer a grant).
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
    assign in_flit_ready[gi] = rst_n && slot_free &&
                               ((state_reg == ARB_IDLE) ? pick_gnt[gi]
                                                        : (owner_reg == OWNER_W'(gi)));
  end

`ifdef FLIT_ARB_TIMEOUT_EN
  localparam int TMO_W = owner_width(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             timeout_pulse_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ARB_IDLE;
      rr_ptr_reg        <= '0;
      owner_reg         <= '0;
      out_valid_reg     <= 1'b0;
      out_flit_reg      <= '0;
`ifdef FLIT_ARB_TIMEOUT_EN
      tmo_cnt_reg       <= '0;
      timeout_pulse_reg <= 1'b0;
`endif
    end else begin
      // Output stage: hold while stalled, otherwise load or empty.
      if (slot_free) begin
        out_valid_reg <= accept;
        if (accept) out_flit_reg <= in_flit[sel_idx];
      end

      if (accept) begin
        owner_reg <= sel_idx;
        if (sel_last) begin
          state_reg  <= ARB_IDLE;
          rr_ptr_reg <= next_ptr;
        end else begin
          state_reg  <= ARB_LOCKED;
        end
      end

`ifdef FLIT_ARB_TIMEOUT_EN
      // Watchdog: only counts idle owner cycles while locked. A timeout can
      // never coincide with an accept because the owner is not valid.
      timeout_pulse_reg <= 1'b0;
      if (state_reg == ARB_LOCKED && !in_flit_valid[owner_reg]) begin
        if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_reg         <= ARB_IDLE;
          rr_ptr_reg        <= next_ptr;
          timeout_pulse_reg <= 1'b1;
          tmo_cnt_reg       <= '0;
        end else begin
          tmo_cnt_reg       <= tmo_cnt_reg + TMO_W'(1);
        end
      end else begin
        tmo_cnt_reg <= '0;
      end
`endif
    end
  end

  assign out_flit       = out_flit_reg;
  assign out_flit_valid = out_valid_reg;
  assign grant_owner    = owner_reg;
`ifdef FLIT_ARB_TIMEOUT_EN
  assign timeout_pulse  = timeout_pulse_reg;
`endif

endmodule
